// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO towards the CPU IO block.
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int DIV     = 434,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               frame_err,
    output logic               overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic               parity_err
`endif
);

    localparam logic [15:0]        BAUD_FULL = 16'(DIV - 1);
    localparam logic [15:0]        BAUD_HALF = 16'(DIV / 2 - 1);
    localparam logic [15:0]        BAUD_ONE  = 16'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(1 << FIFO_AW);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    logic        rx_meta, rxs;
    state_t      state, state_next;
    logic [15:0] baud_cnt, baud_next;
    logic [2:0]  bit_cnt, bit_next;
    logic [7:0]  shift_q, shift_next;
    logic        push, fe_set;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_next, pe_set;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_q   <= shift_next;
            frame_err <= fe_set;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_next;
            parity_err <= pe_set;
`endif
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_q;
        push       = 1'b0;
        fe_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_q;
        pe_set     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    baud_next  = BAUD_HALF;
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        baud_next  = BAUD_FULL;
                        bit_next   = '0;
                        state_next = DATA;
                    end
                end else begin
                    baud_next = baud_cnt - BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    shift_next = {rxs, shift_q[7:1]};
                    baud_next  = BAUD_FULL;
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    baud_next = baud_cnt - BAUD_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt == '0) begin
                    par_next   = rxs;
                    baud_next  = BAUD_FULL;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt - BAUD_ONE;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == '0) begin
                    // A low stop bit wins over any parity verdict.
                    if (!rxs) begin
                        fe_set     = 1'b1;
                        state_next = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        pe_set     = 1'b1;
                        state_next = IDLE;
`endif
                    end else begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - BAUD_ONE;
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO: storage is unreset; occupancy, not pointer equality, tells full from empty.
    logic [7:0]         mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [FIFO_AW:0]   count_next;
    logic               pop, push_ok, head_is_new;

    assign pop         = rx_valid && rx_ready;
    assign push_ok     = push && ((fifo_count != FULL_CNT) || pop);
    assign rd_next     = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign head_is_new = (fifo_count == '0) || (pop && (fifo_count == CNT_ONE));

    always_comb begin
        count_next = fifo_count;
        if (push_ok && !pop)      count_next = fifo_count + CNT_ONE;
        else if (!push_ok && pop) count_next = fifo_count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr     <= rd_next;
            fifo_count <= count_next;
            rx_valid   <= (count_next != '0);
            overrun    <= push && !push_ok;
            // Register the head so rx_data is glitch-free; bypass when the new byte becomes the head.
            if (count_next != '0) rx_data <= (push_ok && head_is_new) ? shift_q : mem[rd_next];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frame driver, queue-based receive model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_uart_rx_fifo;

    localparam int DIV      = 8;
    localparam int AW       = 4;
    localparam int DEPTH    = 16;
    // Frame start to stop-sample edge: 2 sync cycles, IDLE detect, mid-bit, then 9 full bits.
    localparam int PUSH_LAT = 3 + DIV / 2 + 9 * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW:0]   fifo_count;
    logic          frame_err;
    logic          overrun;

    uart_rx_fifo #(.DIV(DIV), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         bad;
    } ev_t;

    ev_t        ev_q[$];
    ev_t        cur_ev;
    logic [7:0] exp_q[$];
    logic [7:0] drain_q[$];
    bit         exp_fe = 1'b0;
    bit         exp_ov = 1'b0;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] drain_at(input int i);
        if (i < drain_q.size()) return drain_q[i];
        return 8'hxx;
    endfunction

    // Receive model: bytes land in the queue at their stop-sample edge, pops leave at the head.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            if (rst_n) begin
                if (exp_q.size() > 0 && rx_ready) void'(exp_q.pop_front());
                while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
                    cur_ev = ev_q.pop_front();
                    if (cur_ev.bad) exp_fe = 1'b1;
                    else if (exp_q.size() < DEPTH) exp_q.push_back(cur_ev.data);
                    else exp_ov = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rx_valid", rx_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) check("rx_data", rx_data, exp_q[0]);
                check("fifo_count", fifo_count, exp_q.size());
                check("frame_err", frame_err, exp_fe);
                check("overrun", overrun, exp_ov);
                if (frame_err) fe_cnt++;
                if (overrun) ov_cnt++;
                if (rx_valid && rx_ready) drain_q.push_back(rx_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic abort_with_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        exp_q.delete();
        ev_q.delete();
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        #1;
        check("reset_mid_valid", rx_valid, 1'b0);
        check("reset_mid_count", fifo_count, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    // Drives one frame LSB-first; stop_low>0 holds the stop bit low that long, abort_at>0 resets mid-frame.
    task automatic send_frame(input logic [7:0] d, input int stop_low, input int abort_at);
        logic [9:0] bits;
        int         c;
        int         len;
        c    = 0;
        bits = {(stop_low == 0), d, 1'b0};
        ev_q.push_back('{cyc + PUSH_LAT, d, (stop_low > 0)});
        for (int b = 0; b < 10; b++) begin
            len = (b == 9 && stop_low > 0) ? stop_low : DIV;
            for (int k = 0; k < len; k++) begin
                if (abort_at > 0 && c == abort_at) begin
                    abort_with_reset();
                    return;
                end
                rx = bits[b];
                tick(1);
                c++;
            end
        end
        rx = 1'b1;
    endtask

    initial begin
        int e_cyc;
        tick(3);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_count", fifo_count, 0);
        check("reset_data", rx_data, 8'h00);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        tick(3);

        // Back-to-back frames, consumer always ready.
        rx_ready = 1'b1;
        drain_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        send_frame(8'hA5, 0, 0);
        send_frame(8'h3C, 0, 0);
        tick(4);
        check("b2b_beats", drain_q.size(), 2);
        check("b2b_first", drain_at(0), 8'hA5);
        check("b2b_second", drain_at(1), 8'h3C);
        check("b2b_errs", fe_cnt + ov_cnt, 0);

        // Glitch shorter than half a bit.
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * DIV);
        check("false_start_count", fifo_count, 0);
        check("false_start_ferr", fe_cnt, 0);

        // Stop bit held low, then a clean frame.
        drain_q.delete();
        send_frame(8'h55, 40, 0);
        tick(2 * DIV);
        check("break_ferr_pulses", fe_cnt, 1);
        send_frame(8'hC3, 0, 0);
        tick(4);
        check("after_break_beats", drain_q.size(), 1);
        check("after_break_data", drain_at(0), 8'hC3);

        // Fill past capacity with no consumer.
        rx_ready = 1'b0;
        drain_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 0, 0);
        tick(4);
        check("full_count", fifo_count, 16);
        check("overrun_pulses", ov_cnt, 1);
        rx_ready = 1'b1;
        tick(20);
        rx_ready = 1'b0;
        check("drain_len", drain_q.size(), 16);
        for (int i = 0; i < DEPTH; i++) check("drain_order", drain_at(i), 8'(i));

        // Full FIFO with a pop landing exactly on the stop-sample edge.
        for (int i = 0; i < DEPTH; i++) send_frame(8'h60 + 8'(i), 0, 0);
        tick(4);
        check("refill_count", fifo_count, 16);
        drain_q.delete();
        ov_cnt = 0;
        e_cyc = cyc + PUSH_LAT;
        fork
            send_frame(8'h77, 0, 0);
            begin
                while (cyc < e_cyc - 1) tick(1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(4);
        check("coincide_count", fifo_count, 16);
        check("coincide_ovr", ov_cnt, 0);
        rx_ready = 1'b1;
        tick(20);
        rx_ready = 1'b0;
        check("coincide_drain_len", drain_q.size(), 17);
        check("coincide_first", drain_at(0), 8'h60);
        check("coincide_last", drain_at(16), 8'h77);

        // Reset in the middle of a data bit with bytes queued.
        drain_q.delete();
        fe_cnt = 0;
        send_frame(8'h11, 0, 0);
        send_frame(8'h22, 0, 0);
        send_frame(8'h33, 0, 0);
        tick(2);
        check("queued_three", fifo_count, 3);
        send_frame(8'hF0, 0, 3 * DIV + 4);
        tick(2 * DIV);
        rx_ready = 1'b1;
        send_frame(8'h81, 0, 0);
        tick(4);
        check("post_reset_beats", drain_q.size(), 1);
        check("post_reset_data", drain_at(0), 8'h81);
        check("post_reset_ferr", fe_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        n_total++;
        $display("FAIL watchdog: simulation still running at cycle %0d, limit 50000", cyc);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
